// File: rtl/formula_fsm_pkg.sv
// formula_fsm_pkg: shared types, isqrt widths and accumulator sizing for formula_sum_isqrt_fsm
package formula_fsm_pkg;
  localparam int ISQRT_W_IN = 32;
  localparam int ISQRT_W_OUT = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  function automatic int acc_w(int n_args);
    return ISQRT_W_OUT + $clog2(n_args);
  endfunction
endpackage

// File: rtl/formula_sum_isqrt_fsm_if.sv
// formula_sum_isqrt_fsm_if: producer request/result handshake plus the isqrt-unit bank bus
//   arg_vld/arg_rdy/args : request from producer
//   res_vld/res          : result pulse and held sum
//   isqrt_x_vld/isqrt_x  : per-unit operand issue
//   isqrt_y_vld/isqrt_y  : per-unit result return
interface formula_sum_isqrt_fsm_if
  import formula_fsm_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int N_ISQRT = 2
);
  logic arg_vld;
  logic arg_rdy;
  logic [ISQRT_W_IN*N_ARGS-1:0] args;
  logic res_vld;
  logic [31:0] res;
  logic [N_ISQRT-1:0] isqrt_x_vld;
  logic [ISQRT_W_IN*N_ISQRT-1:0] isqrt_x;
  logic [N_ISQRT-1:0] isqrt_y_vld;
  logic [ISQRT_W_OUT*N_ISQRT-1:0] isqrt_y;
  modport slave(
    input arg_vld, args, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
  modport master(
    output arg_vld, args, isqrt_y_vld, isqrt_y,
    input arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/isqrt_batch_tracker.sv
// isqrt_batch_tracker: per-unit pending tracking, masked arrival sum and batch completion
//   load/mask   : arm pending with the units issued this cycle
//   y_vld/y     : unit result strobes and values
//   sum         : sum of results from units that were pending this cycle
//   done        : last pending unit(s) return this cycle
module isqrt_batch_tracker
  import formula_fsm_pkg::*;
#(
  parameter int N_ISQRT = 2,
  parameter int SUM_W = 17
) (
  input logic clk,
  input logic rst_n,
  input logic load,
  input logic [N_ISQRT-1:0] mask,
  input logic [N_ISQRT-1:0] y_vld,
  input logic [ISQRT_W_OUT*N_ISQRT-1:0] y,
  output logic [SUM_W-1:0] sum,
  output logic done
);
  logic [N_ISQRT-1:0] pending, arr;
  assign arr = y_vld & pending;
  assign done = |pending && (pending & ~arr) == '0;
  always_comb begin
    sum = '0;
    for (int u = 0; u < N_ISQRT; u++)
      sum = sum + (arr[u] ? SUM_W'(y[ISQRT_W_OUT*u +: ISQRT_W_OUT]) : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pending <= '0;
    else pending <= load ? mask : pending & ~arr;
endmodule

// File: rtl/formula_sum_isqrt_fsm.sv
// formula_sum_isqrt_fsm: res = sum of isqrt(arg[i]) using N_ISQRT external units in batches
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of formula_sum_isqrt_fsm_if (request, result, isqrt bank)
module formula_sum_isqrt_fsm
  import formula_fsm_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int N_ISQRT = 2
) (
  input logic clk,
  input logic rst_n,
  formula_sum_isqrt_fsm_if.slave bus
);
  localparam int N_BATCH = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int ACC_W = acc_w(N_ARGS);
  localparam int BW = N_BATCH > 1 ? $clog2(N_BATCH) : 1;
  localparam int CW = ISQRT_W_IN * N_ISQRT;
  localparam int NP = N_ISQRT * N_BATCH;
  localparam int PW = ISQRT_W_IN * NP;
  if (ACC_W > 32 || N_ISQRT < 1 || N_ISQRT > N_ARGS) begin : g_bad_params
    $error("formula_sum_isqrt_fsm: need 1 <= N_ISQRT <= N_ARGS and 16+clog2(N_ARGS) <= 32");
  end
  state_t state;
  logic [PW-1:0] ops, src;
  logic [NP-1:0] live, live_src;
  logic [BW-1:0] batch;
  logic [ACC_W-1:0] acc, sum;
  logic [31:0] res;
  logic res_vld, done, last, go;
  logic [N_ISQRT-1:0] x_vld;
  logic [CW-1:0] x;
  isqrt_batch_tracker #(.N_ISQRT(N_ISQRT), .SUM_W(ACC_W)) tracker (
    .clk, .rst_n, .load(state == ISSUE), .mask(x_vld),
    .y_vld(bus.isqrt_y_vld), .y(bus.isqrt_y), .sum, .done
  );
  // ops/live form a shift queue of operands and their valid bits; each issue
  // consumes the low N_ISQRT slots, so the first batch comes straight from args.
  always_comb begin
    src = state == IDLE ? PW'(bus.args) : ops;
    live_src = state == IDLE ? NP'({N_ARGS{1'b1}}) : live;
    last = batch == BW'(N_BATCH - 1);
    go = state == IDLE ? bus.arg_vld : state == WAIT && done && !last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ops <= '0;
      live <= '0;
      batch <= '0;
      acc <= '0;
      res <= '0;
      res_vld <= 1'b0;
      x_vld <= '0;
      x <= '0;
    end else begin
      res_vld <= 1'b0;
      x_vld <= '0;
      case (state)
        IDLE: if (bus.arg_vld) begin
          acc <= '0;
          batch <= '0;
          state <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          acc <= acc + sum;
          if (done && last) begin
            res <= 32'(acc + sum);
            res_vld <= 1'b1;
            state <= IDLE;
          end else if (done) begin
            batch <= batch + 1'b1;
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
      if (go) begin
        x_vld <= live_src[N_ISQRT-1:0];
        x <= src[CW-1:0];
        ops <= src >> CW;
        live <= live_src >> N_ISQRT;
      end
    end
  assign bus.arg_rdy = state == IDLE;
  assign bus.res_vld = res_vld;
  assign bus.res = res;
  assign bus.isqrt_x_vld = x_vld;
  assign bus.isqrt_x = x;
endmodule

// File: tb/tb_formula_sum_isqrt_fsm.sv
// tb_formula_sum_isqrt_fsm: three DUT configurations driven with directed and random requests
module tb_formula_sum_isqrt_fsm;
  localparam int NC = 3;
  localparam int MAXA = 5;
  localparam int MAXI = 4;
  localparam int AW = 32 * MAXA;
  function automatic int na_of(int g);
    return g == 0 ? 3 : g == 1 ? 4 : 5;
  endfunction
  function automatic int ni_of(int g);
    return g == 1 ? 4 : 2;
  endfunction
  function automatic logic [15:0] isqrt(logic [31:0] v);
    longint r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= longint'({32'd0, v})) r = t;
    end
    return 16'(r);
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] vld_d = '0;
  logic [NC-1:0][AW-1:0] args_d = '0;
  logic [NC-1:0][MAXI-1:0] spur = '0;
  logic [15:0] spur_y = 16'hffff;
  int lat [NC][MAXI];
  logic [NC-1:0] rdy_o, rv_o;
  logic [NC-1:0][31:0] res_o;
  logic [NC-1:0][MAXI-1:0] xv_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : c
    localparam int NA = na_of(g);
    localparam int NI = ni_of(g);
    formula_sum_isqrt_fsm_if #(.N_ARGS(NA), .N_ISQRT(NI)) bus ();
    formula_sum_isqrt_fsm #(.N_ARGS(NA), .N_ISQRT(NI)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.arg_vld = vld_d[g];
    assign bus.args = args_d[g][32*NA-1:0];
    assign rdy_o[g] = bus.arg_rdy;
    assign rv_o[g] = bus.res_vld;
    assign res_o[g] = bus.res;
    assign xv_o[g] = MAXI'(bus.isqrt_x_vld);
    // isqrt unit model: result returns lat cycles after the issue cycle
    for (genvar u = 0; u < NI; u++) begin : unit
      logic busy;
      int cnt;
      logic [15:0] val;
      always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          busy <= 1'b0;
          cnt <= 0;
          val <= '0;
        end else if (bus.isqrt_x_vld[u]) begin
          busy <= 1'b1;
          cnt <= lat[g][u] - 1;
          val <= isqrt(bus.isqrt_x[32*u +: 32]);
        end else if (busy) begin
          if (cnt == 0) busy <= 1'b0;
          else cnt <= cnt - 1;
        end
      assign bus.isqrt_y_vld[u] = (busy && cnt == 0) || spur[g][u];
      assign bus.isqrt_y[16*u +: 16] = busy ? val : spur_y;
    end
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask
  function automatic logic [AW-1:0] pk(int a0, int a1, int a2, int a3, int a4);
    return {32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction
  function automatic logic [31:0] ref_sum(int g, logic [AW-1:0] a);
    logic [31:0] s = 0;
    for (int i = 0; i < na_of(g); i++) s += 32'(isqrt(a[32*i +: 32]));
    return s;
  endfunction
  // each batch costs one issue cycle plus its slowest active unit
  function automatic int ref_lat(int g);
    int t = 1;
    for (int b = 0; b * ni_of(g) < na_of(g); b++) begin
      int m = 0;
      for (int u = 0; u < ni_of(g); u++)
        if (b * ni_of(g) + u < na_of(g) && lat[g][u] > m) m = lat[g][u];
      t += m + 1;
    end
    return t;
  endfunction
  task automatic do_req(int g, logic [AW-1:0] a, string tag);
    int n, rb;
    logic [31:0] e;
    int el;
    e = ref_sum(g, a);
    el = ref_lat(g);
    chk({tag, ".rdy_idle"}, 32'(rdy_o[g]), 1);
    vld_d[g] = 1'b1;
    args_d[g] = a;
    @(negedge clk);
    vld_d[g] = 1'b0;
    args_d[g] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    n = 1;
    rb = 0;
    while (!rv_o[g] && n < 200) begin
      rb += int'(rdy_o[g]);
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(el));
    chk({tag, ".res"}, res_o[g], e);
    chk({tag, ".rdy_busy"}, 32'(rb), 0);
    chk({tag, ".rdy_at_res"}, 32'(rdy_o[g]), 1);
  endtask
  initial begin
    int n, cnt;
    logic [AW-1:0] a;
    for (int g = 0; g < NC; g++) for (int u = 0; u < MAXI; u++) lat[g][u] = 1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NC; g++) begin
      chk($sformatf("reset.res%0d", g), res_o[g], 0);
      chk($sformatf("reset.rv%0d", g), 32'(rv_o[g]), 0);
      chk($sformatf("reset.rdy%0d", g), 32'(rdy_o[g]), 1);
      chk($sformatf("reset.xv%0d", g), 32'(xv_o[g]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_req(0, pk(16, 25, 36, 0, 0), "t1");
    do_req(0, pk(-1, -1, -1, 0, 0), "t2max");
    chk("t2max.abs", res_o[0], 196605);
    do_req(0, pk(0, 0, 0, 0, 0), "t2zero");
    spur[0] = '1;
    repeat (2) @(negedge clk);
    spur[0] = '0;
    do_req(0, pk(9, 9, 9, 0, 0), "idle_spur");
    lat[0][0] = 5;
    lat[0][1] = 1;
    fork
      do_req(0, pk(1, 4, 9, 0, 0), "t3skew");
      begin
        repeat (4) @(negedge clk);
        spur[0] = 4'b0010;
        @(negedge clk);
        spur[0] = '0;
      end
    join
    lat[0][0] = 1;
    vld_d[0] = 1'b1;
    args_d[0] = pk(16, 25, 36, 0, 0);
    @(negedge clk);
    args_d[0] = pk(49, 64, 81, 0, 0);
    n = 1;
    while (!rv_o[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4.lat1", 32'(n), 5);
    chk("t4.res1", res_o[0], 15);
    chk("t4.rdy1", 32'(rdy_o[0]), 1);
    @(negedge clk);
    vld_d[0] = 1'b0;
    n = 1;
    while (!rv_o[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4.lat2", 32'(n), 5);
    chk("t4.res2", res_o[0], 24);
    lat[0][0] = 5;
    lat[0][1] = 5;
    vld_d[0] = 1'b1;
    args_d[0] = pk(1, 2, 3, 0, 0);
    @(negedge clk);
    vld_d[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5.rv", 32'(rv_o[0]), 0);
    chk("t5.res", res_o[0], 0);
    chk("t5.xv", 32'(xv_o[0]), 0);
    chk("t5.rdy", 32'(rdy_o[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(rv_o[0]);
    end
    chk("t5.no_res", 32'(cnt), 0);
    lat[0][0] = 1;
    lat[0][1] = 1;
    do_req(0, pk(4, 4, 4, 0, 0), "t5after");
    for (int u = 0; u < MAXI; u++) lat[1][u] = 3;
    do_req(1, pk(100, 121, 144, 169, 0), "t6four");
    do_req(2, pk(1, 1, 1, 1, 1), "t6five");
    for (int g = 0; g < NC; g++)
      for (int k = 0; k < 8; k++) begin
        for (int u = 0; u < MAXI; u++) lat[g][u] = $urandom_range(1, 4);
        for (int i = 0; i < MAXA; i++)
          a[32*i +: 32] = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 70000);
        do_req(g, a, $sformatf("rnd%0d_%0d", g, k));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
